des_round_sequencer: RTL and testbench

DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

---
 rtl/des_pkg.sv | 76 +++++++
 rtl/des_round.sv | 151 +++++++++++++++
 rtl/des_round_sequencer.sv | 143 ++++++++++++++
 tb/tb_des_round_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared definitions for the iterative DES round sequencer.
//   - state_t          : sequencer FSM state encoding (IDLE / RUN / DONE)
//   - DES_NUM_ROUNDS   : full DES round count
//   - IP / FP / PC1    : initial, final and key permuted-choice-1 tables,
//                        1-based DES bit numbers with bit 1 = MSB
//   - des_ip/des_fp/des_pc1 : helpers applying those tables
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int DES_NUM_ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // Parity bits 8,16,..,64 never appear, so they are dropped here.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // DES bit n (1-based, MSB first) of a 64-bit word lives at index 64-n.
  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TAB[i]];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] k);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_TAB[i]];
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// -----------------------------------------------------------------------------
// des_round
//   One combinational DES round including its slice of the key schedule.
//   Ports:
//     mode            : 0 = encrypt, 1 = decrypt
//     round [3:0]     : 0-based round index
//     l, r [31:0]     : current Feistel halves
//     c, d [27:0]     : current key halves
//     l_next, r_next  : halves after this round
//     c_next, d_next  : key halves to carry into the next round
//   Encrypt rotates C/D left first and derives the subkey from the rotated
//   value. Decrypt derives the subkey from the incoming C/D (after 16 full
//   encrypt rotations C/D are back to their PC1 value, i.e. K16) and then
//   rotates right by the amount encryption used for the mirrored round.
// -----------------------------------------------------------------------------
module des_round
  import des_pkg::*;
(
  input  logic        mode,
  input  logic [3:0]  round,
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [27:0] c,
  input  logic [27:0] d,
  output logic [31:0] l_next,
  output logic [31:0] r_next,
  output logic [27:0] c_next,
  output logic [27:0] d_next
);

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Eight S-boxes, 64 entries each, indexed box*64 + row*16 + col.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  // Rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) rotate by one, the rest by two.
  function automatic logic single_shift(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_TAB[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    int          idx;
    x = '0;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) x[47-i] = rr[32-E_TAB[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      // Outer bits pick the row, inner four the column.
      idx = b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
      s[31-4*b -: 4] = 4'(SBOX[idx]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_TAB[i]];
    return y;
  endfunction

  logic [27:0] key_c;
  logic [27:0] key_d;
  logic [47:0] subkey;
  logic        enc_one;
  logic        dec_one;

  always_comb begin
    enc_one = single_shift(round);
    dec_one = single_shift(4'd15 - round);
    key_c   = rotl(c, enc_one);
    key_d   = rotl(d, enc_one);
    c_next  = key_c;
    d_next  = key_d;
    if (mode) begin
      key_c  = c;
      key_d  = d;
      c_next = rotr(c, dec_one);
      d_next = rotr(d, dec_one);
    end
    subkey = pc2({key_c, key_d});
    l_next = r;
    r_next = l ^ feistel(r, subkey);
  end

endmodule

// File: rtl/des_round_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_sequencer
//   Iterative DES engine: one round per clock through a single des_round.
//   Build option: DES_DECRYPT_EN adds the in_mode port (0 = encrypt,
//   1 = decrypt); without it the engine only encrypts.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     in_valid/ready  : request handshake (block + key [+ mode])
//     in_data [63:0]  : input block, bit 63 = DES bit 1
//     in_key  [63:0]  : DES key, parity bits ignored
//     in_mode         : direction (DES_DECRYPT_EN only)
//     out_valid/ready : result handshake
//     out_data [63:0] : result block
//     busy            : high while a block is in RUN or DONE
//     fsm_state       : current FSM state for observation
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; in_ready is high only in IDLE and out_valid only in DONE,
//   neither depends combinationally on the opposite valid, and out_data is
//   held constant for as long as out_valid is high.
//   Timing: accept edge -> NUM_ROUNDS RUN cycles -> DONE; with out_ready high
//   the next accept can happen NUM_ROUNDS+2 edges after the previous one.
// -----------------------------------------------------------------------------
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
`ifdef DES_DECRYPT_EN
  input  logic        in_mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output state_t      fsm_state
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [31:0] l;
  logic [31:0] r;
  logic [27:0] c;
  logic [27:0] d;
  logic        mode;
  logic [31:0] l_next;
  logic [31:0] r_next;
  logic [27:0] c_next;
  logic [27:0] d_next;
  logic        load;
  logic        run;
  logic        last;

  assign last = (cnt == LAST_ROUND);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    run        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      l        <= '0;
      r        <= '0;
      c        <= '0;
      d        <= '0;
      out_data <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        {l, r} <= des_ip(in_data);
        {c, d} <= des_pc1(in_key);
        cnt    <= 4'd0;
      end else if (run) begin
        l   <= l_next;
        r   <= r_next;
        c   <= c_next;
        d   <= d_next;
        cnt <= cnt + 4'd1;
        // The halves are swapped back before the final permutation.
        if (last) out_data <= des_fp({r_next, l_next});
      end
    end
  end

`ifdef DES_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
    end else if (load) begin
      mode <= in_mode;
    end
  end
`else
  assign mode = 1'b0;
`endif

  des_round u_round (
    .mode   (mode),
    .round  (cnt),
    .l      (l),
    .r      (r),
    .c      (c),
    .d      (d),
    .l_next (l_next),
    .r_next (r_next),
    .c_next (c_next),
    .d_next (d_next)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_des_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_round_sequencer
//   Scoreboard bench: drivers push expected results (known answers or a
//   textbook DES model with a precomputed subkey array) into exp_q, and a
//   monitor pops and compares whenever out_valid rises, also checking the
//   accept-to-valid latency and that out_data holds while out_valid is high.
// -----------------------------------------------------------------------------
module tb_des_round_sequencer;
  import des_pkg::*;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  state_t      fsm_state;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q [$];
  int unsigned acc_q [$];
  bit          rand_ready = 1'b0;

  des_round_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
`ifdef DES_DECRYPT_EN
    .in_mode   (in_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  localparam int M_IP [64] = '{
    58,50,42,34,26,18,10, 2,60,52,44,36,28,20,12, 4,
    62,54,46,38,30,22,14, 6,64,56,48,40,32,24,16, 8,
    57,49,41,33,25,17, 9, 1,59,51,43,35,27,19,11, 3,
    61,53,45,37,29,21,13, 5,63,55,47,39,31,23,15, 7};
  localparam int M_FP [64] = '{
    40, 8,48,16,56,24,64,32,39, 7,47,15,55,23,63,31,
    38, 6,46,14,54,22,62,30,37, 5,45,13,53,21,61,29,
    36, 4,44,12,52,20,60,28,35, 3,43,11,51,19,59,27,
    34, 2,42,10,50,18,58,26,33, 1,41, 9,49,17,57,25};
  localparam int M_PC1 [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,
    19,11, 3,60,52,44,36,63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int M_PC2 [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int M_E [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
  localparam int M_P [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int M_SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic int m_entry(input int which, input int i);
    case (which)
      0:       return M_IP[i];
      1:       return M_FP[i];
      2:       return M_PC1[i];
      3:       return M_PC2[i];
      4:       return M_E[i];
      default: return M_P[i];
    endcase
  endfunction

  // Generic table permutation: output bit i (MSB first) = input DES bit tab[i].
  function automatic logic [63:0] m_perm(input logic [63:0] x, input int in_w, input int which);
    logic [63:0] y;
    int          n_out;
    y = '0;
    n_out = (which == 2) ? 56 : (which == 3 || which == 4) ? 48 : (which == 5) ? 32 : 64;
    for (int i = 0; i < n_out; i++) y[n_out-1-i] = x[in_w - m_entry(which, i)];
    return y;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] rr, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s;
    int          row;
    int          col;
    t = m_perm({32'h0, rr}, 32, 4);
    x = t[47:0] ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      row = 2 * int'(x[47-6*b]) + int'(x[42-6*b]);
      col = int'(x[46-6*b -: 4]);
      s[31-4*b -: 4] = 4'(M_SB[b*64 + row*16 + col]);
    end
    t = m_perm({32'h0, s}, 32, 5);
    return t[31:0];
  endfunction

  // Textbook DES: build all 16 subkeys, decrypt simply uses them in reverse.
  function automatic logic [63:0] des_model(input logic [63:0] data, input logic [63:0] key,
                                            input logic mode, input int n);
    logic [63:0] t;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] ks [16];
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] tmp;
    int          sh;
    t = m_perm(key, 64, 2);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = m_perm({8'h0, c, d}, 56, 3);
      ks[i] = t[47:0];
    end
    t = m_perm(data, 64, 0);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < n; i++) begin
      tmp = r;
      r   = l ^ m_f(r, mode ? ks[15-i] : ks[i]);
      l   = tmp;
    end
    return m_perm({r, l}, 64, 1);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare on the first cycle of each out_valid, then hold-check.
  initial begin : monitor
    logic [63:0] held;
    bit          holding;
    int unsigned acc;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else if (out_valid) begin
        if (!holding) begin
          holding = 1'b1;
          held    = out_data;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid actual=%h required=none", out_data);
          end else begin
            check("result", out_data, exp_q.pop_front());
            acc = acc_q.pop_front();
            check("latency", 64'(cyc - acc), 64'(NR + 1));
          end
        end else begin
          check("hold_data", out_data, held);
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin : ready_randomizer
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [63:0] data, input logic [63:0] key, input logic mode,
                      input logic [63:0] expect_val, output int unsigned acc);
    int budget;
    budget = 0;
    acc    = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_key   = key;
    in_mode  = mode;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_in_ready required=in_ready");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc = cyc;
      exp_q.push_back(expect_val);
      acc_q.push_back(acc);
      @(negedge clk);
      // Scramble the inputs after accept; they must not influence the result.
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_key   = {$urandom, $urandom};
      in_mode  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  function automatic logic pick_mode();
`ifdef DES_DECRYPT_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    int unsigned a1;
    int unsigned a2;
    logic [63:0] dat;
    logic [63:0] key;
    logic        md;
    int          n;

    // Reset with in_valid high: reset must win.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h0123456789ABCDEF;
    in_key    = 64'h133457799BBCDFF1;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    rst      = 1'b0;
    in_valid = 1'b0;

    // Known answers.
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, a1);
    check("busy_in_run", 64'(busy), 64'd1);
    wait_drain();
    send(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000, a1);
    wait_drain();
`ifdef DES_DECRYPT_EN
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF, a1);
    wait_drain();
`endif

    // Backpressure: hold DONE for 10 cycles while a stray request is offered.
    out_ready = 1'b0;
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, a1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_high", 64'(out_valid), 64'd1);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_key   = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    repeat (20) @(negedge clk);

    // Reset during round 7 abandons the block.
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, a1);
    repeat (7) @(negedge clk);
    check("pre_rst_state", 64'(fsm_state), 64'(RUN));
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", 64'(fsm_state), 64'(IDLE));
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    repeat (25) @(negedge clk);
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, a1);
    wait_drain();

    // Back-to-back with out_ready held high.
    dat = {$urandom, $urandom};
    key = {$urandom, $urandom};
    md  = pick_mode();
    send(dat, key, md, des_model(dat, key, md, NR), a1);
    dat = {$urandom, $urandom};
    key = {$urandom, $urandom};
    md  = pick_mode();
    send(dat, key, md, des_model(dat, key, md, NR), a2);
    check("b2b_spacing", 64'(a2 - a1), 64'(NR + 2));
    wait_drain();

    // Random traffic with random backpressure and gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dat = {$urandom, $urandom};
      key = {$urandom, $urandom};
      md  = pick_mode();
      send(dat, key, md, des_model(dat, key, md, NR), a1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    @(negedge clk);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
